// File: rtl/gray_counter_pkg.sv
// Shared constants and helpers for the prescaled Gray-code counter.
// gray2bin is not used by the RTL; it is provided for decoding the count elsewhere.
package gray_counter_pkg;

   localparam int N_MAX = 8;

   function automatic logic [N_MAX-1:0] bin2gray(input logic [N_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [N_MAX-1:0] gray2bin(input logic [N_MAX-1:0] g);
      logic [N_MAX-1:0] b;
      b[N_MAX-1] = g[N_MAX-1];
      for (int i = N_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Prescaler width: clog2(div), never narrower than one bit.
   function automatic int pre_width(input longint unsigned div);
      int w;
      w = $clog2(div);
      return (w < 32'sd1) ? 32'sd1 : w;
   endfunction

endpackage

// File: rtl/gray_counter_param_tick_prescaler.sv
// Free-running divide-by-DIV prescaler; tick is high on the last enabled cycle of each period.
module tick_prescaler
   import gray_counter_pkg::*;
#(
   parameter int unsigned DIV = 32'd25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int             PW       = pre_width(longint'(DIV));
   localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 32'd1);

   logic [PW-1:0] r_pre;

   // Prescale counter: wraps at DIV-1, so with DIV=1 it stays at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre <= '0;
      end else if (clr) begin
         r_pre <= '0;
      end else if (en) begin
         if (r_pre == PRE_LAST) begin
            r_pre <= '0;
         end else begin
            r_pre <= r_pre + PW'(32'd1);
         end
      end else begin
         r_pre <= r_pre;
      end
   end

   assign tick = en && (r_pre == PRE_LAST);

endmodule

// File: rtl/gray_counter_param.sv
// Prescaled N-bit Gray-code counter with registered step/wrap pulses.
// Build option GRAY_COUNTER_UPDOWN_EN enables down counting through dir.
module gray_counter_param
   import gray_counter_pkg::*;
#(
   parameter int          N   = 5,
   parameter int unsigned DIV = 32'd25000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic         dir,
   output logic [N-1:0] gray_count,
   output logic         step,
   output logic         wrap
);

   logic         w_tick;
   logic [N-1:0] w_bin_next;
   logic [N-1:0] w_gray_next;
   logic         w_wrap_next;
   logic [N-1:0] r_bin;
   logic [N-1:0] r_gray;
   logic         r_step;
   logic         r_wrap;

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .tick  (w_tick)
   );

   // Next binary value and terminal-count detect for the coming step.
`ifdef GRAY_COUNTER_UPDOWN_EN
   always_comb begin
      w_bin_next  = r_bin + N'(32'd1);
      w_wrap_next = (r_bin == {N{1'b1}});
      if (dir) begin
         w_bin_next  = r_bin - N'(32'd1);
         w_wrap_next = (r_bin == {N{1'b0}});
      end else begin
         w_bin_next  = r_bin + N'(32'd1);
         w_wrap_next = (r_bin == {N{1'b1}});
      end
   end
`else
   logic w_dir_unused;
   assign w_dir_unused = dir;

   always_comb begin
      w_bin_next  = r_bin + N'(32'd1);
      w_wrap_next = (r_bin == {N{1'b1}});
   end
`endif

   // Gray value is derived from the new binary count so both update together.
   assign w_gray_next = N'(bin2gray(N_MAX'(w_bin_next)));

   // Count pipeline: reset beats clr, clr beats counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
      end else if (clr) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
      end else if (w_tick) begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_step <= 1'b1;
         r_wrap <= w_wrap_next;
      end else begin
         r_bin  <= r_bin;
         r_gray <= r_gray;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
      end
   end

   assign gray_count = r_gray;
   assign step       = r_step;
   assign wrap       = r_wrap;

endmodule
